// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture block: controller state encoding,
// default thresholds and small helpers used by the top level.
package trace_pkg;

   // Controller states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HOLD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   // Default program-complete PC threshold
   localparam logic [63:0] END_PC_DEFAULT = 64'h0000_0000_0000_0054;

   // Default maximum number of RUN cycles before a timeout
   localparam int unsigned WDOG_LIMIT_DEFAULT = 32'd255;

   // Width of one trace entry: {pc, writeback value}
   localparam int unsigned ENTRY_W = 32'd128;

   // True while a processor run is being prepared or executed
   function automatic logic is_busy_state(input state_e s);
      logic r;
      case (s)
         ST_HOLD: r = 1'b1;
         ST_RUN:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace FIFO: registered storage, power-of-two depth, free-running wrapping
// pointers and an occupancy counter one bit wider than the pointers.
module trace_fifo #(
   parameter int unsigned DEPTH = 32'd16,
   parameter int unsigned WIDTH = 32'd128
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
   localparam int unsigned CW = AW + 32'd1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_ptr_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             push_ok;
   logic             pop_ok;

   // Accept a pop only when data is present; a push into a full FIFO is
   // accepted only when a pop frees the slot in the same cycle
   always_comb begin
      pop_ok   = pop_i && (cnt_q != {CW{1'b0}});
      push_ok  = push_i && ((cnt_q != FULL_CNT) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers; reset and clear empty the FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage write; suppressed during reset and clear
   always_ff @(posedge clk_i) begin
      if (push_ok && !rst_i && !clr_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/trace_capture.sv
// Trace capture controller: launches a processor run (reset hold, then RUN),
// records {pc, writeback} every RUN cycle into a FIFO, and finishes on the
// completion PC or on watchdog expiry.
module trace_capture
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH      = 32'd16,
   parameter logic [63:0] END_PC     = END_PC_DEFAULT,
   parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        start,
   input  logic [63:0] startpc_in,
   input  logic [63:0] currentpc,
   input  logic [63:0] MemtoRegOut,
   output logic        cpu_resetl,
   output logic [63:0] startpc,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [63:0] rd_pc,
   output logic [63:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        overflow,
   output logic [63:0] final_result
);

   localparam int unsigned WDOG_W = (WDOG_LIMIT < 32'd2) ? 32'd1 : $clog2(WDOG_LIMIT + 32'd1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

   state_e              state_q;
   state_e              state_d;
   logic                hold_cnt_q;
   logic                hold_cnt_d;
   logic [WDOG_W-1:0]   wdog_q;
   logic [WDOG_W-1:0]   wdog_d;
   logic [63:0]         startpc_q;
   logic [63:0]         startpc_d;
   logic [63:0]         final_q;
   logic [63:0]         final_d;
   logic                done_q;
   logic                done_d;
   logic                timeout_q;
   logic                timeout_d;
   logic                ovf_q;
   logic                ovf_d;
   logic                cpu_resetl_q;
   logic                busy_q;

   logic                push_req;
   logic                fifo_clr;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ENTRY_W-1:0]  fifo_rdata;
   logic                pc_reached;

   assign pc_reached = (currentpc >= END_PC);
   assign fifo_pop   = !fifo_empty && rd_ready;

   // Next-state, datapath updates and push request
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      wdog_d     = wdog_q;
      startpc_d  = startpc_q;
      final_d    = final_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      ovf_d      = ovf_q;
      push_req   = 1'b0;
      fifo_clr   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_TIMEOUT: begin
            if (start) begin
               state_d    = ST_HOLD;
               startpc_d  = startpc_in;
               done_d     = 1'b0;
               timeout_d  = 1'b0;
               ovf_d      = 1'b0;
               wdog_d     = {WDOG_W{1'b0}};
               hold_cnt_d = 1'b0;
               fifo_clr   = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_HOLD: begin
            // Processor reset is held for two cycles before running
            if (hold_cnt_q) begin
               state_d    = ST_RUN;
               hold_cnt_d = 1'b0;
            end else begin
               hold_cnt_d = 1'b1;
            end
         end
         ST_RUN: begin
            // Completion PC takes priority over the watchdog limit
            if (pc_reached) begin
               push_req = 1'b1;
               final_d  = MemtoRegOut;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end else if (wdog_q == WDOG_MAX) begin
               timeout_d = 1'b1;
               state_d   = ST_TIMEOUT;
            end else begin
               push_req = 1'b1;
               wdog_d   = wdog_q + WDOG_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A push into a full FIFO with no simultaneous pop is dropped
      if (push_req && fifo_full && !fifo_pop) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_d;
      end
   end

   // Controller and status registers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         hold_cnt_q   <= 1'b0;
         wdog_q       <= {WDOG_W{1'b0}};
         startpc_q    <= 64'h0;
         final_q      <= 64'h0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         ovf_q        <= 1'b0;
         cpu_resetl_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         wdog_q       <= wdog_d;
         startpc_q    <= startpc_d;
         final_q      <= final_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         ovf_q        <= ovf_d;
         cpu_resetl_q <= (state_d != ST_HOLD);
         busy_q       <= is_busy_state(state_d);
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .clr_i   (fifo_clr),
      .push_i  (push_req),
      .pop_i   (fifo_pop),
      .wdata_i ({currentpc, MemtoRegOut}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cpu_resetl   = cpu_resetl_q;
   assign startpc      = startpc_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign timeout      = timeout_q;
   assign overflow     = ovf_q;
   assign final_result = final_q;
   assign rd_valid     = !fifo_empty;
   assign rd_pc        = fifo_rdata[127:64];
   assign rd_data      = fifo_rdata[63:0];

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a simple processor PC model.
module tb_trace_capture;

   logic        CLK;
   logic        Reset;
   logic        start;
   logic [63:0] startpc_in;
   logic [63:0] currentpc;
   logic [63:0] MemtoRegOut;
   logic        cpu_resetl;
   logic [63:0] startpc;
   logic        rd_valid;
   logic        rd_ready;
   logic [63:0] rd_pc;
   logic [63:0] rd_data;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        overflow;
   logic [63:0] final_result;

   int          n_checks;
   int          n_fail;
   int          pc_mode;      // 0: step by 4, 1: stuck at 0x10, 2: 0x10 then 0x54 at run cycle 255
   int          run_idx;
   logic [63:0] nxt_pc;
   int          lows;
   int          post_done;
   logic [63:0] q_pc[$];
   logic [63:0] q_data[$];

   trace_capture dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .start        (start),
      .startpc_in   (startpc_in),
      .currentpc    (currentpc),
      .MemtoRegOut  (MemtoRegOut),
      .cpu_resetl   (cpu_resetl),
      .startpc      (startpc),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_pc        (rd_pc),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .overflow     (overflow),
      .final_result (final_result)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [63:0] dval(input logic [63:0] pc);
      return {pc[31:0] ^ 32'hA5A5_0000, ~pc[31:0]};
   endfunction

   // Processor model: PC loads startpc while held in reset, otherwise advances
   always @(posedge CLK) begin
      if (cpu_resetl === 1'b0) begin
         run_idx = 0;
         nxt_pc  = (pc_mode == 0) ? startpc : 64'h10;
      end else begin
         run_idx = run_idx + 1;
         case (pc_mode)
            0:       nxt_pc = currentpc + 64'd4;
            1:       nxt_pc = 64'h10;
            default: nxt_pc = (run_idx == 255) ? 64'h54 : 64'h10;
         endcase
      end
      #1;
      currentpc   = nxt_pc;
      MemtoRegOut = dval(nxt_pc);
   end

   task automatic pulse_start(input logic [63:0] spc);
      @(posedge CLK); #1;
      startpc_in = spc;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   // Collect pops until done/timeout; rd_ready rises when the model presents ready_pc
   task automatic collect(input int budget, input logic [63:0] ready_pc, output bit ended);
      ended = 1'b0; lows = 0; post_done = 0;
      q_pc.delete(); q_data.delete();
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (!cpu_resetl) lows++;
         if (busy && cpu_resetl && currentpc == ready_pc) rd_ready = 1'b1;
         if (rd_valid && rd_ready) begin
            q_pc.push_back(rd_pc); q_data.push_back(rd_data);
            if (done) post_done++;
         end
         if (done || timeout) begin ended = 1'b1; break; end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         rd_ready = 1'b1;
         if (rd_valid) begin
            q_pc.push_back(rd_pc); q_data.push_back(rd_data); post_done++;
         end else break;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; start = 1'b0; rd_ready = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (cpu_resetl !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_resetl: got %b expected 0", cpu_resetl); end
      n_checks++; if (startpc !== 64'h0) begin n_fail++; $display("FAIL rst_startpc: got %h expected 0", startpc); end
      n_checks++; if (final_result !== 64'h0) begin n_fail++; $display("FAIL rst_final: got %h expected 0", final_result); end
      n_checks++; if ({busy, done, timeout, overflow, rd_valid} !== 5'b0) begin n_fail++; $display("FAIL rst_status: got %b expected 00000", {busy, done, timeout, overflow, rd_valid}); end
      Reset = 1'b0;
      @(negedge CLK);
      n_checks++; if (cpu_resetl !== 1'b1) begin n_fail++; $display("FAIL rst_release_cpu_resetl: got %b expected 1", cpu_resetl); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_full_run();
      bit ended; int bad;
      pc_mode = 0; rd_ready = 1'b1;
      pulse_start(64'h0);
      collect(200, 64'h0, ended);
      drain();
      n_checks++; if (ended !== 1'b1) begin n_fail++; $display("FAIL run_ended: got %b expected 1", ended); end
      n_checks++; if (lows !== 2) begin n_fail++; $display("FAIL run_hold_cycles: got %0d expected 2", lows); end
      n_checks++; if (q_pc.size() !== 22) begin n_fail++; $display("FAIL run_entries: got %0d expected 22", q_pc.size()); end
      bad = 0;
      foreach (q_pc[i]) if (q_pc[i] !== 64'(4 * i) || q_data[i] !== dval(64'(4 * i))) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL run_order: got %0d bad entries expected 0", bad); end
      n_checks++; if ({done, timeout, busy, overflow} !== 4'b1000) begin n_fail++; $display("FAIL run_status: got %b expected 1000", {done, timeout, busy, overflow}); end
      n_checks++; if (final_result !== dval(64'h54)) begin n_fail++; $display("FAIL run_final: got %h expected %h", final_result, dval(64'h54)); end
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL run_empty: got %b expected 0", rd_valid); end
   endtask

   task automatic test_end_boundary();
      bit ended;
      pc_mode = 0; rd_ready = 1'b1;
      pulse_start(64'h54);
      collect(50, 64'h0, ended);
      drain();
      n_checks++; if (startpc !== 64'h54) begin n_fail++; $display("FAIL bnd_startpc: got %h expected 54", startpc); end
      n_checks++; if (q_pc.size() !== 1) begin n_fail++; $display("FAIL bnd_entries: got %0d expected 1", q_pc.size()); end
      n_checks++; if (q_pc.size() > 0 && q_pc[0] !== 64'h54) begin n_fail++; $display("FAIL bnd_pc: got %h expected 54", q_pc[0]); end
      n_checks++; if ({done, timeout} !== 2'b10) begin n_fail++; $display("FAIL bnd_status: got %b expected 10", {done, timeout}); end
      n_checks++; if (final_result !== dval(64'h54)) begin n_fail++; $display("FAIL bnd_final: got %h expected %h", final_result, dval(64'h54)); end
   endtask

   task automatic test_overflow();
      bit ended; int bad;
      pc_mode = 0; rd_ready = 1'b0;
      pulse_start(64'h0);
      collect(200, 64'hFFFF_FFFF_FFFF_FFFF, ended);
      n_checks++; if ({done, overflow} !== 2'b11) begin n_fail++; $display("FAIL ovf_status: got %b expected 11", {done, overflow}); end
      drain();
      n_checks++; if (q_pc.size() !== 16) begin n_fail++; $display("FAIL ovf_entries: got %0d expected 16", q_pc.size()); end
      bad = 0;
      foreach (q_pc[i]) if (q_pc[i] !== 64'(4 * i) || q_data[i] !== dval(64'(4 * i))) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovf_order: got %0d bad entries expected 0", bad); end
   endtask

   task automatic test_full_pop();
      bit ended; int bad;
      pc_mode = 0; rd_ready = 1'b0;
      pulse_start(64'h0);
      collect(200, 64'h40, ended);
      drain();
      n_checks++; if ({done, overflow} !== 2'b10) begin n_fail++; $display("FAIL fullpop_status: got %b expected 10", {done, overflow}); end
      n_checks++; if (post_done !== 16) begin n_fail++; $display("FAIL fullpop_occupancy: got %0d expected 16", post_done); end
      n_checks++; if (q_pc.size() !== 22) begin n_fail++; $display("FAIL fullpop_entries: got %0d expected 22", q_pc.size()); end
      bad = 0;
      foreach (q_pc[i]) if (q_pc[i] !== 64'(4 * i)) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL fullpop_order: got %0d bad entries expected 0", bad); end
   endtask

   task automatic test_timeout();
      bit ended; int bad;
      pc_mode = 1; rd_ready = 1'b1;
      pulse_start(64'h0);
      collect(400, 64'h0, ended);
      @(negedge CLK);
      n_checks++; if (ended !== 1'b1) begin n_fail++; $display("FAIL tmo_ended: got %b expected 1", ended); end
      n_checks++; if ({timeout, done, busy, overflow} !== 4'b1000) begin n_fail++; $display("FAIL tmo_status: got %b expected 1000", {timeout, done, busy, overflow}); end
      n_checks++; if (q_pc.size() !== 255) begin n_fail++; $display("FAIL tmo_entries: got %0d expected 255", q_pc.size()); end
      bad = 0;
      foreach (q_pc[i]) if (q_pc[i] !== 64'h10) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tmo_pc: got %0d bad entries expected 0", bad); end
   endtask

   task automatic test_wdog_boundary();
      bit ended;
      pc_mode = 2; rd_ready = 1'b1;
      pulse_start(64'h0);
      collect(400, 64'h0, ended);
      drain();
      n_checks++; if ({done, timeout} !== 2'b10) begin n_fail++; $display("FAIL wdb_status: got %b expected 10", {done, timeout}); end
      n_checks++; if (q_pc.size() !== 256) begin n_fail++; $display("FAIL wdb_entries: got %0d expected 256", q_pc.size()); end
      n_checks++; if (q_pc.size() > 0 && q_pc[q_pc.size() - 1] !== 64'h54) begin n_fail++; $display("FAIL wdb_last_pc: got %h expected 54", q_pc[q_pc.size() - 1]); end
      n_checks++; if (final_result !== dval(64'h54)) begin n_fail++; $display("FAIL wdb_final: got %h expected %h", final_result, dval(64'h54)); end
   endtask

   task automatic test_reset_midrun();
      int runs; bit hit;
      pc_mode = 0; rd_ready = 1'b0; runs = 0; hit = 1'b0;
      pulse_start(64'h0);
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (busy && cpu_resetl) runs++;
         if (runs == 5) begin hit = 1'b1; break; end
      end
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL mid_reached_run: got %b expected 1", hit); end
      Reset = 1'b1;
      @(negedge CLK);
      n_checks++; if ({rd_valid, busy, done, timeout, overflow} !== 5'b0) begin n_fail++; $display("FAIL mid_status: got %b expected 00000", {rd_valid, busy, done, timeout, overflow}); end
      n_checks++; if (cpu_resetl !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_resetl: got %b expected 0", cpu_resetl); end
      Reset = 1'b0;
      @(negedge CLK);
      n_checks++; if ({cpu_resetl, busy, rd_valid} !== 3'b100) begin n_fail++; $display("FAIL mid_release: got %b expected 100", {cpu_resetl, busy, rd_valid}); end
      test_full_run();
   endtask

   initial begin
      n_checks = 0; n_fail = 0; pc_mode = 0; run_idx = 0;
      Reset = 1'b1; start = 1'b0; rd_ready = 1'b0;
      startpc_in = 64'h0; currentpc = 64'h0; MemtoRegOut = 64'h0;
      test_reset();
      test_full_run();
      test_end_boundary();
      test_overflow();
      test_full_pop();
      test_timeout();
      test_wdog_boundary();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 16: trace FIFO entries, power of two, 2..256.
REQ-002 Parameter END_PC, default 64'h54: program-complete PC threshold.
REQ-003 Parameter WDOG_LIMIT, default 255: maximum RUN cycles before timeout.
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to launch a processor run.
REQ-007 startpc_in  in  64  start PC forwarded to processor.
REQ-008 currentpc  in  64  processor current PC.
REQ-009 MemtoRegOut  in  64  processor writeback value.
REQ-010 cpu_resetl  out  1  active-low reset to processor.
REQ-011 startpc  out  64  latched start PC to processor.
REQ-012 rd_valid  out  1  FIFO head valid.
REQ-013 rd_ready  in  1  reader accepts head.
REQ-014 rd_pc  out  64  head PC.
REQ-015 rd_data  out  64  head writeback value.
REQ-016 busy, done, timeout, overflow  out  1 each  status.
REQ-017 final_result  out  64  MemtoRegOut sampled on the completing cycle.

Function
REQ-018 States IDLE, HOLD, RUN, DONE, TIMEOUT; encoding 3 bits.
REQ-019 IDLE: start=1 -> HOLD; latch startpc_in into startpc; clear done, timeout, overflow, FIFO, watchdog.
REQ-020 HOLD: cpu_resetl=0 for exactly 2 cycles, then RUN; cpu_resetl=1 in all other states.
REQ-021 RUN: each cycle push {currentpc, MemtoRegOut} into FIFO; watchdog increments by 1.
REQ-022 RUN, currentpc >= END_PC (unsigned): push that entry, load final_result, -> DONE, done=1.
REQ-023 RUN, watchdog == WDOG_LIMIT and PC condition false: -> TIMEOUT, timeout=1, no push that cycle.
REQ-024 PC condition and watchdog limit in the same cycle: PC condition wins (DONE).
REQ-025 DONE/TIMEOUT: start=1 -> HOLD (restart as REQ-019); otherwise hold.
REQ-026 start ignored in HOLD and RUN.
REQ-027 busy=1 in HOLD and RUN only.
REQ-028 FIFO full and push required: entry dropped, overflow set sticky until next start; FIFO contents unchanged.
REQ-029 Pop when rd_valid && rd_ready; simultaneous push and pop when full: both performed, no overflow.
REQ-030 rd_valid = FIFO non-empty; rd_pc/rd_data show head, stable while rd_valid && !rd_ready.
REQ-031 Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-032 Reading allowed in every state; FIFO not cleared at DONE/TIMEOUT.
REQ-033 Push-to-rd_valid latency 1 cycle (registered storage).

Reset
REQ-034 Reset=1 at a rising edge: state IDLE, FIFO empty, cpu_resetl=0, startpc=0, final_result=0, all status 0, watchdog 0.
REQ-035 Reset mid-RUN aborts run; no entry pushed in the reset cycle.
REQ-036 First cycle after Reset deasserts: cpu_resetl=1, state IDLE.

Structure
REQ-037 State encoding and default END_PC/WDOG_LIMIT constants in shared package trace_pkg.
REQ-038 FIFO is sub-module trace_fifo (128-bit data, DEPTH parameter, full/empty, push/pop).

Verification
REQ-039 start with startpc_in=0, PC model stepping 0,4,...,0x54, reader always ready -> cpu_resetl low 2 cycles, 22 entries popped in order, done=1, final_result equals value at PC 0x54.
REQ-040 PC stuck at 0x10 -> timeout=1 after 255 RUN cycles, done=0, busy=0.
REQ-041 DEPTH=16, rd_ready=0, 22-step program -> 16 entries retained (PCs 0..0x3C), overflow=1, done=1.
REQ-042 Full FIFO with rd_ready=1 during RUN -> no overflow, occupancy stays 16.
REQ-043 Reset asserted at RUN cycle 5 -> IDLE, rd_valid=0, all status 0 next cycle; start again -> clean run passes REQ-039.
REQ-044 PC reaches 0x54 on the cycle watchdog hits 255 -> DONE, timeout=0.
